// File: rtl/regfile_dump.sv
// regfile_dump: walks a contiguous, possibly wrapping, index range through one regfile
// read port and streams (index, value) pairs out over a valid/ready handshake.
module regfile_dump #(
    parameter int n = 16,
    parameter int r = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [r-1:0] first,
    input  logic [r-1:0] last,
    output logic         busy,
    output logic         done,
    output logic [r-1:0] ra,
    input  logic [n-1:0] rd,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [r-1:0] m_idx,
    output logic [n-1:0] m_data,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [r-1:0] PTR_ONE = r'(1);

    state_t         state_q;
    logic [r-1:0]   ptr_q;
    logic [r-1:0]   last_q;
    logic           done_q;
    logic           m_valid_q;
    logic [r-1:0]   m_idx_q;
    logic [n-1:0]   m_data_q;
    logic           out_free;

    // Handshake: a beat transfers on a rising edge where m_valid and m_ready are both
    // high; m_valid, m_idx and m_data hold unchanged until that edge (or rst).
    assign out_free = !m_valid_q || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            last_q    <= '0;
            done_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_idx_q   <= '0;
            m_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q   <= first;
                        last_q  <= last;
                        state_q <= READ;
                    end
                end
                READ: begin
                    // A stalled output register means no read is consumed; ptr holds.
                    if (out_free) begin
                        m_data_q  <= rd;
                        m_idx_q   <= ptr_q;
                        m_valid_q <= 1'b1;
                        if (ptr_q == last_q) begin
                            state_q <= DRAIN;
                        end else begin
                            ptr_q <= ptr_q + PTR_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (m_valid_q && m_ready) begin
                        m_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                        ptr_q     <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign ra          = ptr_q;
    assign m_valid     = m_valid_q;
    assign m_idx       = m_idx_q;
    assign m_data      = m_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural 8x16 regfile with read-before-write semantics
// feeds the read port; a negedge monitor records every accepted beat and done pulse.
module tb_regfile_dump;
    localparam int N = 16;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [R-1:0] first = '0;
    logic [R-1:0] last = '0;
    logic         busy;
    logic         done;
    logic [R-1:0] ra;
    logic [N-1:0] rd;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [R-1:0] m_idx;
    logic [N-1:0] m_data;
    logic [1:0]   dbg_state;

    logic [N-1:0] mem [8];
    logic         we3 = 1'b0;
    logic [R-1:0] wa3 = '0;
    logic [N-1:0] wd3 = '0;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int overlap_cnt = 0;

    logic [R-1:0] got_idx [$];
    logic [N-1:0] got_data [$];
    int           got_cyc [$];
    int           done_cyc [$];
    logic [R-1:0] exp_idx [$];
    logic [N-1:0] exp_data [$];

    regfile_dump #(.n(N), .r(R)) dut (
        .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
        .busy(busy), .done(done), .ra(ra), .rd(rd),
        .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_data(m_data),
        .dbg_state_o(dbg_state)
    );

    // clock / reset block and regfile model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (we3) mem[wa3] <= wd3;
    assign rd = mem[ra];

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_idx.push_back(m_idx);
                got_data.push_back(m_data);
                got_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (done && busy) overlap_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_idx.delete();
        got_data.delete();
        got_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic do_write(input logic [R-1:0] a, input logic [N-1:0] d);
        we3 = 1'b1; wa3 = a; wd3 = d;
        tick();
        we3 = 1'b0;
    endtask

    task automatic start_dump(input logic [R-1:0] f, input logic [R-1:0] l);
        first = f; last = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        tests_run++;
        if (done_cyc.size() == 0) begin
            fails++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tests_run++;
        if ({busy, done, m_valid} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b want 000", {busy, done, m_valid});
        end
        tests_run++;
        if (m_idx !== 3'd0 || ra !== 3'd0) begin
            fails++; $display("FAIL reset_idx_ra: got m_idx=%0d ra=%0d want 0 0", m_idx, ra);
        end
        tests_run++;
        if (m_data !== 16'h0000) begin
            fails++; $display("FAIL reset_data: got %h want 0000", m_data);
        end
        tests_run++;
        if (dbg_state !== 2'd0) begin
            fails++; $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
    endtask

    task automatic test_basic();
        int n0;
        clear_mon();
        exp_idx = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_data = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        n0 = cyc;
        start_dump(3'd1, 3'd4);
        tests_run++;
        if (busy !== 1'b1 || m_valid !== 1'b0 || ra !== 3'd1) begin
            fails++; $display("FAIL basic_after_start: got busy=%b valid=%b ra=%0d want 1 0 1", busy, m_valid, ra);
        end
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 4) begin
            fails++; $display("FAIL basic_count: got %0d want 4", got_idx.size());
        end
        for (int k = 0; k < 4 && k < got_idx.size(); k++) begin
            tests_run++;
            if (got_idx[k] !== exp_idx[k] || got_data[k] !== exp_data[k] || got_cyc[k] !== n0 + 2 + k) begin
                fails++;
                $display("FAIL basic_beat%0d: got (%0d,%h)@%0d want (%0d,%h)@%0d", k, got_idx[k], got_data[k],
                         got_cyc[k], exp_idx[k], exp_data[k], n0 + 2 + k);
            end
        end
        tests_run++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== n0 + 6) begin
            fails++; $display("FAIL basic_done: got %0d pulses first@%0d want 1 @%0d", done_cyc.size(),
                              (done_cyc.size() > 0) ? done_cyc[0] : -1, n0 + 6);
        end
        tests_run++;
        if (busy !== 1'b0 || ra !== 3'd0) begin
            fails++; $display("FAIL basic_idle: got busy=%b ra=%0d want 0 0", busy, ra);
        end
    endtask

    task automatic test_wrap();
        clear_mon();
        exp_idx = '{3'd6, 3'd7, 3'd0, 3'd1};
        exp_data = '{16'h0066, 16'h0077, 16'h0000, 16'h0011};
        start_dump(3'd6, 3'd1);
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 4 || done_cyc.size() !== 1) begin
            fails++; $display("FAIL wrap_count: got beats=%0d done=%0d want 4 1", got_idx.size(), done_cyc.size());
        end
        for (int k = 0; k < 4 && k < got_idx.size(); k++) begin
            tests_run++;
            if (got_idx[k] !== exp_idx[k] || got_data[k] !== exp_data[k]) begin
                fails++; $display("FAIL wrap_beat%0d: got (%0d,%h) want (%0d,%h)", k, got_idx[k], got_data[k],
                                  exp_idx[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_single();
        int n0;
        clear_mon();
        n0 = cyc;
        start_dump(3'd5, 3'd5);
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 1 || got_idx[0] !== 3'd5 || got_data[0] !== 16'h0055) begin
            fails++; $display("FAIL single_beat: got %0d beats first (%0d,%h) want 1 (5,0055)", got_idx.size(),
                              got_idx[0], got_data[0]);
        end
        tests_run++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== n0 + 3) begin
            fails++; $display("FAIL single_done: got %0d pulses want 1 @%0d", done_cyc.size(), n0 + 3);
        end
    endtask

    task automatic test_full();
        clear_mon();
        exp_idx = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        exp_data = '{16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0000, 16'h0011, 16'h0022};
        start_dump(3'd3, 3'd2);
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 8 || done_cyc.size() !== 1) begin
            fails++; $display("FAIL full_count: got beats=%0d done=%0d want 8 1", got_idx.size(), done_cyc.size());
        end
        for (int k = 0; k < 8 && k < got_idx.size(); k++) begin
            tests_run++;
            if (got_idx[k] !== exp_idx[k] || got_data[k] !== exp_data[k]) begin
                fails++; $display("FAIL full_beat%0d: got (%0d,%h) want (%0d,%h)", k, got_idx[k], got_data[k],
                                  exp_idx[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        clear_mon();
        exp_idx = '{3'd1, 3'd2, 3'd3};
        exp_data = '{16'h0011, 16'h0022, 16'h0033};
        n0 = cyc;
        start_dump(3'd1, 3'd3);
        m_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            tests_run++;
            if (m_valid !== 1'b1 || m_idx !== 3'd1 || m_data !== 16'h0011 || done !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got valid=%b (%0d,%h) done=%b want 1 (1,0011) 0", s, m_valid,
                                  m_idx, m_data, done);
            end
        end
        tick();
        m_ready = 1'b1;
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 3 || done_cyc.size() !== 1) begin
            fails++; $display("FAIL bp_count: got beats=%0d done=%0d want 3 1", got_idx.size(), done_cyc.size());
        end
        for (int k = 0; k < 3 && k < got_idx.size(); k++) begin
            tests_run++;
            if (got_idx[k] !== exp_idx[k] || got_data[k] !== exp_data[k] || got_cyc[k] !== n0 + 5 + k) begin
                fails++; $display("FAIL bp_beat%0d: got (%0d,%h)@%0d want (%0d,%h)@%0d", k, got_idx[k], got_data[k],
                                  got_cyc[k], exp_idx[k], exp_data[k], n0 + 5 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        start_dump(3'd1, 3'd6);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_idx !== 3'd0) begin
            fails++; $display("FAIL rstmid_clear: got valid=%b busy=%b done=%b idx=%0d want 0 0 0 0", m_valid, busy,
                              done, m_idx);
        end
        repeat (4) tick();
        tests_run++;
        if (got_idx.size() !== 2 || done_cyc.size() !== 0) begin
            fails++; $display("FAIL rstmid_abort: got beats=%0d done=%0d want 2 0", got_idx.size(), done_cyc.size());
        end
        clear_mon();
        start_dump(3'd2, 3'd3);
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 2 || got_idx[0] !== 3'd2 || got_data[0] !== 16'h0022 ||
            got_idx[1] !== 3'd3 || got_data[1] !== 16'h0033 || done_cyc.size() !== 1) begin
            fails++; $display("FAIL rstmid_restart: got %0d beats (%0d,%h) (%0d,%h) done=%0d want 2 (2,0022) (3,0033) 1",
                              got_idx.size(), got_idx[0], got_data[0], got_idx[1], got_data[1], done_cyc.size());
        end
    endtask

    task automatic test_collision();
        clear_mon();
        exp_data = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        start_dump(3'd1, 3'd4);
        tick();
        // start while busy, with a range that would give 8 beats if accepted
        first = 3'd0; last = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        we3 = 1'b1; wa3 = 3'd3; wd3 = 16'hBEEF;
        tick();
        we3 = 1'b0;
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 4 || done_cyc.size() !== 1) begin
            fails++; $display("FAIL coll_count: got beats=%0d done=%0d want 4 1", got_idx.size(), done_cyc.size());
        end
        for (int k = 0; k < 4 && k < got_idx.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_data[k]) begin
                fails++; $display("FAIL coll_beat%0d: got %h want %h", k, got_data[k], exp_data[k]);
            end
        end
        clear_mon();
        start_dump(3'd3, 3'd3);
        wait_done(40);
        tests_run++;
        if (got_idx.size() !== 1 || got_data[0] !== 16'hBEEF) begin
            fails++; $display("FAIL coll_newval: got %0d beats data %h want 1 BEEF", got_idx.size(), got_data[0]);
        end
    endtask

    task automatic test_overlap();
        tests_run++;
        if (overlap_cnt !== 0) begin
            fails++; $display("FAIL busy_done_overlap: got %0d cycles want 0", overlap_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        for (int i = 1; i < 8; i++) do_write(3'(i), 16'(16'h0011 * i));
        tick();
        test_basic();
        test_wrap();
        test_single();
        test_full();
        test_backpressure();
        test_reset_mid();
        test_collision();
        test_overlap();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
